// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Two-stage pipelined carry-lookahead adder/subtractor built from 4-bit
//   lookahead groups. Stage 1 registers bit and group propagate/generate plus
//   the effective carry-in. Stage 2 resolves group carries with a second-level
//   lookahead, forms the sum and the status flags, and registers them.
//   Valid/ready handshake on both sides, one operation per cycle.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block can accept an operand beat
//   a, b       operands (WIDTH bits)
//   cin        carry-in, ignored when sub=1
//   sub        1: compute a - b
//   out_valid  result valid
//   out_ready  downstream accepts result
//   sum        result (WIDTH bits, modulo 2^WIDTH)
//   cout       carry out of MSB (sub: 1 = no borrow)
//   ovf        signed overflow
//   blk_p      AND of all group propagates
//   blk_g      block generate, carry-in excluded
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             blk_p,
  output logic             blk_g
);

  localparam int unsigned GROUPS = WIDTH / 4;

  if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_width_check
    $error("pipelined_cla_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  // Carry into position n as a flat sum of products:
  //   ci&p[0..n-1] | g[0]&p[1..n-1] | ... | g[n-1]
  // Every term is an independent AND, so no position waits on another.
  function automatic logic sop_carry(input logic [WIDTH-1:0] gv,
                                     input logic [WIDTH-1:0] pv,
                                     input logic             ci,
                                     input int unsigned      n);
    logic carry;
    logic prod;
    carry = ci;
    for (int unsigned m = 0; m < n; m++) carry = carry & pv[m];
    for (int unsigned j = 0; j < n; j++) begin
      prod = gv[j];
      for (int unsigned m = j + 1; m < n; m++) prod = prod & pv[m];
      carry = carry | prod;
    end
    return carry;
  endfunction

  // Handshake
  logic s1_valid;
  logic adv1, adv2, accept;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = s1_valid && adv2;
  assign in_ready = !s1_valid || adv2;
  assign accept   = in_valid && in_ready;

  // Stage 1 combinational: bit and group propagate/generate
  logic [WIDTH-1:0]  b_eff, p_in, g_in;
  logic [GROUPS-1:0] gp_in, gg_in;
  logic              c0_in;

  always_comb begin
    b_eff = sub ? ~b : b;
    c0_in = sub | cin;
    p_in  = a ^ b_eff;
    g_in  = a & b_eff;
    gp_in = '0;
    gg_in = '0;
    for (int unsigned k = 0; k < GROUPS; k++) begin
      gp_in[k] = &p_in[4*k +: 4];
      gg_in[k] = sop_carry(WIDTH'(g_in[4*k +: 4]), WIDTH'(p_in[4*k +: 4]), 1'b0, 4);
    end
  end

  logic [WIDTH-1:0]  s1_p, s1_g;
  logic [GROUPS-1:0] s1_gp, s1_gg;
  logic              s1_c0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_gp    <= '0;
      s1_gg    <= '0;
      s1_c0    <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (accept) begin
        s1_p  <= p_in;
        s1_g  <= g_in;
        s1_gp <= gp_in;
        s1_gg <= gg_in;
        s1_c0 <= c0_in;
      end
    end
  end

  // Stage 2 combinational: group carries, in-group carries, sum and flags
  logic [GROUPS-1:0] gc;
  logic [WIDTH-1:0]  c;
  logic [WIDTH-1:0]  sum_d;
  logic              cout_d, ovf_d, blk_p_d, blk_g_d;

  always_comb begin
    gc = '0;
    c  = '0;
    for (int unsigned k = 0; k < GROUPS; k++) begin
      gc[k] = sop_carry(WIDTH'(s1_gg), WIDTH'(s1_gp), s1_c0, k);
    end
    for (int unsigned k = 0; k < GROUPS; k++) begin
      for (int unsigned i = 0; i < 4; i++) begin
        c[4*k + i] = sop_carry(WIDTH'(s1_g[4*k +: 4]), WIDTH'(s1_p[4*k +: 4]), gc[k], i);
      end
    end
    sum_d   = s1_p ^ c;
    cout_d  = sop_carry(WIDTH'(s1_gg), WIDTH'(s1_gp), s1_c0, GROUPS);
    blk_g_d = sop_carry(WIDTH'(s1_gg), WIDTH'(s1_gp), 1'b0, GROUPS);
    blk_p_d = &s1_gp;
    ovf_d   = c[WIDTH-1] ^ cout_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      blk_p     <= 1'b0;
      blk_g     <= 1'b0;
    end else begin
      if (adv2) out_valid <= s1_valid;
      if (adv1) begin
        sum   <= sum_d;
        cout  <= cout_d;
        ovf   <= ovf_d;
        blk_p <= blk_p_d;
        blk_g <= blk_g_d;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, cin, sub;
  logic [31:0] a, b;

  always #5 clk = ~clk;

  logic        in_ready4, out_valid4, cout4, ovf4, blkp4, blkg4;
  logic [3:0]  sum4;
  logic        in_ready8, out_valid8, cout8, ovf8, blkp8, blkg8;
  logic [7:0]  sum8;
  logic        in_ready, out_valid, cout, ovf, blk_p, blk_g;
  logic [15:0] sum;
  logic        in_ready32, out_valid32, cout32, ovf32, blkp32, blkg32;
  logic [31:0] sum32;

  pipelined_cla_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a[3:0]), .b(b[3:0]), .cin(cin), .sub(sub), .out_valid(out_valid4),
    .out_ready(out_ready), .sum(sum4), .cout(cout4), .ovf(ovf4),
    .blk_p(blkp4), .blk_g(blkg4));

  pipelined_cla_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub), .out_valid(out_valid8),
    .out_ready(out_ready), .sum(sum8), .cout(cout8), .ovf(ovf8),
    .blk_p(blkp8), .blk_g(blkg8));

  pipelined_cla_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf),
    .blk_p(blk_p), .blk_g(blk_g));

  pipelined_cla_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid32),
    .out_ready(out_ready), .sum(sum32), .cout(cout32), .ovf(ovf32),
    .blk_p(blkp32), .blk_g(blkg32));

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Reference: plain integer arithmetic. Returns {ovf, cout, sum[31:0]}.
  function automatic logic [33:0] model(input int unsigned w, input logic [31:0] aa,
                                        input logic [31:0] bb, input logic ci,
                                        input logic su);
    longint unsigned mask, x, y, full;
    longint          sx, sy, r, lim;
    logic            co, ov;
    mask = (64'd1 << w) - 64'd1;
    x    = longint'(aa) & mask;
    y    = longint'(bb) & mask;
    lim  = longint'(64'd1 << (w - 1));
    sx   = (x >= 64'(lim)) ? longint'(x) - 2 * lim : longint'(x);
    sy   = (y >= 64'(lim)) ? longint'(y) - 2 * lim : longint'(y);
    if (su) begin
      full = (x - y) & mask;
      co   = (x >= y);
      r    = sx - sy;
    end else begin
      full = x + y + longint'(ci);
      co   = ((full >> w) & 64'd1) != 0;
      full = full & mask;
      r    = sx + sy + longint'(ci);
    end
    ov = (r < -lim) || (r >= lim);
    return {ov, co, full[31:0]};
  endfunction

  task automatic send(input logic [31:0] aa, input logic [31:0] bb, input logic c, input logic s);
    @(negedge clk);
    a = aa; b = bb; cin = c; sub = s; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    total++;
    if ({in_ready, out_valid, cout, ovf, blk_p, blk_g, sum} !== {1'b1, 5'b0, 16'h0})
      $display("FAIL reset: rdy/vld/cout/ovf/bp/bg/sum got %b_%b_%b_%b_%b_%b_%h required 1_0_0_0_0_0_0000",
               in_ready, out_valid, cout, ovf, blk_p, blk_g, sum);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_wrap();
    out_ready = 1'b1;
    send(32'hFFFF, 32'h0001, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b0) $display("FAIL t1_latency_early: out_valid got %b required 0", out_valid);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, sum, cout, ovf, blk_p, blk_g} !== {1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1})
      $display("FAIL t1_result: vld/sum/cout/ovf/bp/bg got %b/%h/%b/%b/%b/%b required 1/0000/1/0/0/1",
               out_valid, sum, cout, ovf, blk_p, blk_g);
    else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_overflow();
    bit ok;
    out_ready = 1'b1;
    send(32'h7FFF, 32'h0001, 1'b0, 1'b0);
    wait_out(ok);
    total++;
    if (!ok || {sum, cout, ovf} !== {16'h8000, 1'b0, 1'b1})
      $display("FAIL t2_ovf: ok/sum/cout/ovf got %b/%h/%b/%b required 1/8000/0/1", ok, sum, cout, ovf);
    else passed++;
    @(posedge clk); #1;
    send(32'h0000, 32'hFFFF, 1'b1, 1'b0);
    wait_out(ok);
    total++;
    if (!ok || {sum, cout, ovf, blk_p, blk_g} !== {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0})
      $display("FAIL t2_propagate: ok/sum/cout/ovf/bp/bg got %b/%h/%b/%b/%b/%b required 1/0000/1/0/1/0",
               ok, sum, cout, ovf, blk_p, blk_g);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_subtract();
    bit ok;
    out_ready = 1'b1;
    send(32'h0005, 32'h0007, 1'b0, 1'b1);
    wait_out(ok);
    total++;
    if (!ok || {sum, cout, ovf} !== {16'hFFFE, 1'b0, 1'b0})
      $display("FAIL t3_borrow: ok/sum/cout/ovf got %b/%h/%b/%b required 1/fffe/0/0", ok, sum, cout, ovf);
    else passed++;
    @(posedge clk); #1;
    // cin=0 here on purpose: subtract must force carry-in to 1 regardless
    send(32'h8000, 32'h0001, 1'b0, 1'b1);
    wait_out(ok);
    total++;
    if (!ok || {sum, cout, ovf} !== {16'h7FFF, 1'b1, 1'b1})
      $display("FAIL t3_sub_ovf: ok/sum/cout/ovf got %b/%h/%b/%b required 1/7fff/1/1", ok, sum, cout, ovf);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    int unsigned idx = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (idx < 4) begin
        a = 32'(idx + 1); b = 32'(idx + 1); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      end
      #1;
      if (out_valid) begin
        total++;
        if (sum !== 16'h0002) $display("FAIL t4_hold: sum got %h required 0002 (cycle %0d)", sum, cyc);
        else passed++;
      end
      if (in_valid && in_ready) idx++;
    end
    total++;
    if (idx != 2 || in_ready !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL t4_full: accepted/in_ready/out_valid got %0d/%b/%b required 2/0/1", idx, in_ready, out_valid);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (idx < 4) begin
        a = 32'(idx + 1); b = 32'(idx + 1); in_valid = 1'b1;
      end else in_valid = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b1 || sum !== 16'(2 * (k + 1)))
        $display("FAIL t4_release: beat %0d vld/sum got %b/%h required 1/%h", k, out_valid, sum, 16'(2 * (k + 1)));
      else passed++;
      if (in_valid && in_ready) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    @(negedge clk);
    a = 32'h1; b = 32'h1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 32'h2; b = 32'h2;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, sum, cout, ovf, in_ready} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b1})
      $display("FAIL t5_async: vld/sum/cout/ovf/rdy got %b/%h/%b/%b/%b required 0/0000/0/0/1",
               out_valid, sum, cout, ovf, in_ready);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0) $display("FAIL t5_stale: out_valid got %b required 0 (cycle %0d)", out_valid, i);
      else passed++;
    end
    send(32'h0005, 32'h0006, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b0) $display("FAIL t5_latency_early: out_valid got %b required 0", out_valid);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || sum !== 16'h000B)
      $display("FAIL t5_latency: vld/sum got %b/%h required 1/000b", out_valid, sum);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [33:0] q4[$], q8[$], q16[$], q32[$];
    logic [33:0] e;
    for (int cyc = 0; cyc < 3006; cyc++) begin
      @(negedge clk);
      if (cyc < 3000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      #1;
      if (out_valid4 && out_ready) begin
        total++;
        if (q4.size() == 0) $display("FAIL rand_w4: unexpected beat sum %h", sum4);
        else begin
          e = q4.pop_front();
          if ({ovf4, cout4, 28'h0, sum4} !== e)
            $display("FAIL rand_w4: ovf/cout/sum got %b/%b/%h required %b/%b/%h", ovf4, cout4, sum4, e[33], e[32], e[3:0]);
          else passed++;
        end
      end
      if (out_valid8 && out_ready) begin
        total++;
        if (q8.size() == 0) $display("FAIL rand_w8: unexpected beat sum %h", sum8);
        else begin
          e = q8.pop_front();
          if ({ovf8, cout8, 24'h0, sum8} !== e)
            $display("FAIL rand_w8: ovf/cout/sum got %b/%b/%h required %b/%b/%h", ovf8, cout8, sum8, e[33], e[32], e[7:0]);
          else passed++;
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (q16.size() == 0) $display("FAIL rand_w16: unexpected beat sum %h", sum);
        else begin
          e = q16.pop_front();
          if ({ovf, cout, 16'h0, sum} !== e)
            $display("FAIL rand_w16: ovf/cout/sum got %b/%b/%h required %b/%b/%h", ovf, cout, sum, e[33], e[32], e[15:0]);
          else passed++;
        end
      end
      if (out_valid32 && out_ready) begin
        total++;
        if (q32.size() == 0) $display("FAIL rand_w32: unexpected beat sum %h", sum32);
        else begin
          e = q32.pop_front();
          if ({ovf32, cout32, sum32} !== e)
            $display("FAIL rand_w32: ovf/cout/sum got %b/%b/%h required %b/%b/%h", ovf32, cout32, sum32, e[33], e[32], e[31:0]);
          else passed++;
        end
      end
      if (in_valid && in_ready4)  q4.push_back(model(4, a, b, cin, sub));
      if (in_valid && in_ready8)  q8.push_back(model(8, a, b, cin, sub));
      if (in_valid && in_ready)   q16.push_back(model(16, a, b, cin, sub));
      if (in_valid && in_ready32) q32.push_back(model(32, a, b, cin, sub));
    end
    total++;
    if (q4.size() != 0 || q8.size() != 0 || q16.size() != 0 || q32.size() != 0)
      $display("FAIL rand_drain: outstanding w4/w8/w16/w32 got %0d/%0d/%0d/%0d required 0/0/0/0",
               q4.size(), q8.size(), q16.size(), q32.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_overflow();
    test_subtract();
    test_stall();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
